// File: rtl/elevador_controle.sv
// Car controller for the 3-floor elevator: latches hall calls, moves the car, dwells at served floors.
// Optional emergency stop input `parar` is enabled by defining ELEVADOR_EMERGENCIA_EN.
module elevador_controle #(
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       B1,
    input  logic       B2,
    input  logic       B3,
`ifdef ELEVADOR_EMERGENCIA_EN
    input  logic       parar,
`endif
    output logic       M,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic [1:0] andar,
    output logic       sobe
);

    localparam int unsigned MaxCycles = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned CW        = $clog2(MaxCycles) + 1;

    typedef enum logic [1:0] {StParado, StMovendo, StPorta} estado_t;

    estado_t       estado_q, estado_d;
    logic [1:0]    andar_q, andar_d, andar_prox;
    logic          sobe_q, sobe_d;
    logic [2:0]    pending_q, pending_d;
    logic [CW-1:0] viagem_q, viagem_d;
    logic [CW-1:0] porta_q, porta_d;
    logic [2:0]    botoes, set_mask, limpa;
    logic          freio;
    logic          m_d;
    logic [2:0]    a_d;

    // Bit 0 of every floor mask is floor 1.
    function automatic logic [2:0] mascara(input logic [1:0] f);
        case (f)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic ha_acima(input logic [1:0] f, input logic [2:0] p);
        case (f)
            2'd1:    return p[1] | p[2];
            2'd2:    return p[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ha_abaixo(input logic [1:0] f, input logic [2:0] p);
        case (f)
            2'd3:    return p[1] | p[0];
            2'd2:    return p[0];
            default: return 1'b0;
        endcase
    endfunction

`ifdef ELEVADOR_EMERGENCIA_EN
    assign freio = parar;
`else
    assign freio = 1'b0;
`endif

    assign botoes = {B3, B2, B1};
    assign andar_prox = sobe_q ? andar_q + 2'd1 : andar_q - 2'd1;

    always_comb begin
        estado_d = estado_q;
        andar_d  = andar_q;
        sobe_d   = sobe_q;
        viagem_d = viagem_q;
        porta_d  = porta_q;
        limpa    = 3'b000;
        set_mask = botoes;
        // A press of the floor being served only restarts the dwell.
        if (estado_q == StPorta) begin
            set_mask = botoes & ~mascara(andar_q);
        end

        case (estado_q)
            StParado: begin
                if (|(pending_q & mascara(andar_q))) begin
                    estado_d = StPorta;
                    porta_d  = '0;
                    limpa    = mascara(andar_q);
                end else if (|pending_q) begin
                    if (sobe_q ? !ha_acima(andar_q, pending_q) : !ha_abaixo(andar_q, pending_q)) begin
                        sobe_d = !sobe_q;
                    end
                    estado_d = StMovendo;
                    viagem_d = '0;
                end
            end
            StMovendo: begin
                if (!freio) begin
                    if (viagem_q == CW'(TRAVEL_CYCLES - 1)) begin
                        viagem_d = '0;
                        andar_d  = andar_prox;
                        if (|(pending_q & mascara(andar_prox))) begin
                            estado_d = StPorta;
                            porta_d  = '0;
                            limpa    = mascara(andar_prox);
                        end else if (sobe_q ? !ha_acima(andar_prox, pending_q)
                                            : !ha_abaixo(andar_prox, pending_q)) begin
                            // Nothing left ahead: stop rather than run past an end floor.
                            estado_d = StParado;
                        end
                    end else begin
                        viagem_d = viagem_q + CW'(1);
                    end
                end
            end
            StPorta: begin
                if (|(botoes & mascara(andar_q))) begin
                    porta_d = '0;
                end else if (porta_q == CW'(DOOR_CYCLES - 1)) begin
                    estado_d = StParado;
                    porta_d  = '0;
                end else begin
                    porta_d = porta_q + CW'(1);
                end
            end
            default: estado_d = StParado;
        endcase

        pending_d = (pending_q | set_mask) & ~limpa;

        m_d = (estado_d == StMovendo) && !((estado_q == StMovendo) && freio);
        a_d = (estado_d == StMovendo) ? 3'b000 : mascara(andar_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= StParado;
            andar_q   <= 2'd1;
            sobe_q    <= 1'b1;
            pending_q <= 3'b000;
            viagem_q  <= '0;
            porta_q   <= '0;
            M         <= 1'b0;
            A1        <= 1'b1;
            A2        <= 1'b0;
            A3        <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            andar_q   <= andar_d;
            sobe_q    <= sobe_d;
            pending_q <= pending_d;
            viagem_q  <= viagem_d;
            porta_q   <= porta_d;
            M         <= m_d;
            A1        <= a_d[0];
            A2        <= a_d[1];
            A3        <= a_d[2];
        end
    end

    assign andar = andar_q;
    assign sobe  = sobe_q;

endmodule

// File: tb/tb_elevador_controle.sv
// Directed bench for elevador_controle: cycle-exact call scenarios plus a per-cycle output invariant monitor.
module tb_elevador_controle;

    logic       clock;
    logic       reset;
    logic       B1, B2, B3;
    logic       M, A1, A2, A3;
    logic [1:0] andar;
    logic       sobe;
`ifdef ELEVADOR_EMERGENCIA_EN
    logic       parar;
    logic       parar_prev;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic mon_en = 1'b0;

    elevador_controle #(
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .B1   (B1),
        .B2   (B2),
        .B3   (B3),
`ifdef ELEVADOR_EMERGENCIA_EN
        .parar(parar),
`endif
        .M    (M),
        .A1   (A1),
        .A2   (A2),
        .A3   (A3),
        .andar(andar),
        .sobe (sobe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // b is {B1,B2,B3}, held for exactly one sampling edge.
    task automatic press(input logic [2:0] b);
        {B1, B2, B3} = b;
        step();
        {B1, B2, B3} = 3'b000;
    endtask

    // a is {A1,A2,A3}; checks the current cycle then advances, n times.
    task automatic expect_run(input string tag, input logic m, input logic [2:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_M"}, 32'(M), 32'(m));
            check({tag, "_A"}, 32'({A1, A2, A3}), 32'(a));
            step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_M"}, 32'(M), 32'd0);
        check({tag, "_A"}, 32'({A1, A2, A3}), 32'b100);
        check({tag, "_andar"}, 32'(andar), 32'd1);
        check({tag, "_sobe"}, 32'(sobe), 32'd1);
    endtask

`ifdef ELEVADOR_EMERGENCIA_EN
    always @(posedge clock) parar_prev <= parar;
`endif

    // Legal output combinations, every cycle after the first reset.
    initial begin
        logic [2:0] a;
        logic [2:0] floor_a;
        logic       relax;
        wait (mon_en);
        forever begin
            @(negedge clock);
            a = {A1, A2, A3};
            floor_a = (andar == 2'd1) ? 3'b100 : (andar == 2'd2) ? 3'b010 :
                      (andar == 2'd3) ? 3'b001 : 3'b000;
`ifdef ELEVADOR_EMERGENCIA_EN
            relax = parar | parar_prev;
`else
            relax = 1'b0;
`endif
            check("inv_andar_nonzero", 32'(andar != 2'd0), 32'd1);
            if (M) begin
                check("inv_moving_no_floor", 32'(a), 32'd0);
                check("inv_no_saturated_move",
                      32'((andar == 2'd3 && sobe) || (andar == 2'd1 && !sobe)), 32'd0);
            end else begin
                check("inv_stopped_onehot", 32'((a == floor_a) || (relax && a == 3'b000)), 32'd1);
            end
        end
    end

    initial begin
        reset = 1'b1;
        {B1, B2, B3} = 3'b000;
`ifdef ELEVADOR_EMERGENCIA_EN
        parar = 1'b0;
`endif
        step();
        step();
        check_reset_values("reset");
        reset = 1'b0;
        mon_en = 1'b1;
        expect_run("idle_after_reset", 1'b0, 3'b100, 3);

        // Floor 1 -> 3, single call.
        press(3'b001);
        expect_run("b3_parado", 1'b0, 3'b100, 1);
        expect_run("b3_move", 1'b1, 3'b000, 8);
        expect_run("b3_door", 1'b0, 3'b001, 3);
        expect_run("b3_idle", 1'b0, 3'b001, 2);
        check("b3_andar", 32'(andar), 32'd3);
        check("b3_sobe", 32'(sobe), 32'd1);

        // Calls at 2 and 3 together: stop at 2, then continue to 3.
        do_reset();
        press(3'b011);
        expect_run("b23_parado", 1'b0, 3'b100, 1);
        expect_run("b23_move1", 1'b1, 3'b000, 4);
        expect_run("b23_door2", 1'b0, 3'b010, 4);
        expect_run("b23_move2", 1'b1, 3'b000, 4);
        expect_run("b23_door3", 1'b0, 3'b001, 3);
        check("b23_andar", 32'(andar), 32'd3);

        // Call for floor 1 while travelling 2 -> 3.
        do_reset();
        press(3'b001);
        expect_run("rev_parado", 1'b0, 3'b100, 1);
        expect_run("rev_move_up", 1'b1, 3'b000, 5);
        check("rev_andar_mid", 32'(andar), 32'd2);
        press(3'b100);
        expect_run("rev_move_up2", 1'b1, 3'b000, 2);
        expect_run("rev_door3", 1'b0, 3'b001, 3);
        check("rev_sobe_before", 32'(sobe), 32'd1);
        expect_run("rev_parado3", 1'b0, 3'b001, 1);
        check("rev_sobe_flipped", 32'(sobe), 32'd0);
        expect_run("rev_move_down", 1'b1, 3'b000, 8);
        expect_run("rev_door1", 1'b0, 3'b100, 3);
        check("rev_andar_end", 32'(andar), 32'd1);

        // Call at the current floor, re-pressed during dwell.
        do_reset();
        press(3'b100);
        expect_run("here_parado", 1'b0, 3'b100, 1);
        expect_run("here_dwell1", 1'b0, 3'b100, 1);
        B1 = 1'b1;
        expect_run("here_dwell2", 1'b0, 3'b100, 1);
        B1 = 1'b0;
        press(3'b010);
        expect_run("here_dwell_ext", 1'b0, 3'b100, 2);
        expect_run("here_parado2", 1'b0, 3'b100, 1);
        expect_run("here_move", 1'b1, 3'b000, 2);

        // Reset in mid-travel, then stays idle.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_values("reset_mid");
        expect_run("reset_mid_idle", 1'b0, 3'b100, 3);

`ifdef ELEVADOR_EMERGENCIA_EN
        // Emergency stop for 5 cycles on the way 1 -> 2.
        do_reset();
        press(3'b010);
        expect_run("stop_parado", 1'b0, 3'b100, 1);
        expect_run("stop_move_a", 1'b1, 3'b000, 2);
        parar = 1'b1;
        expect_run("stop_move_b", 1'b1, 3'b000, 1);
        expect_run("stop_frozen", 1'b0, 3'b000, 4);
        check("stop_andar", 32'(andar), 32'd1);
        parar = 1'b0;
        expect_run("stop_frozen_last", 1'b0, 3'b000, 1);
        expect_run("stop_resume", 1'b1, 3'b000, 1);
        expect_run("stop_door2", 1'b0, 3'b010, 3);
        check("stop_andar_end", 32'(andar), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
